// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings, the master/slave fail code and default bus widths.
package apb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_state_t;

  // Two-bit fail code understood by the master: {timeout, slverr}
  typedef struct packed {
    logic timeout;
    logic slverr;
  } apb_fail_t;

endpackage

// File: rtl/apb_regfile.sv
// Register storage: synchronous write, combinational read, index 0 hard-wired to the ID constant.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned         NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Writes to index 0 are dropped; the ID slot is never backed by storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr == '0) ? ID_VALUE : mem[raddr];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer serving a word-addressed register bank with fixed wait states and error response.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           NUM_REGS    = 8,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL_slv_i,
  input  logic                  PENABLE_slv_i,
  input  logic                  PWRITE_slv_i,
  input  logic [ADDR_WIDTH-1:0] PADDR_slv_i,
  input  logic [DATA_WIDTH-1:0] PWDATA_slv_i,
  output logic [DATA_WIDTH-1:0] PRDATA_slv_o,
  output logic                  PREADY_slv_o,
  output logic                  PSLVERR_slv_o
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned CW = 4;

  apb_state_t state, state_nx;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  pready_d;
  logic                  pslverr_d;
  logic                  we_c;
  logic                  setup_c;
  logic                  err_c;
  logic [IW-1:0]         idx_c;

  assign setup_c = PSEL_slv_i && !PENABLE_slv_i;
  assign idx_c   = PADDR_slv_i[IW+1:2];

  // Misaligned, out of range (full-width compare) or a write to the ID register
  assign err_c = (PADDR_slv_i[1:0] != 2'b00)
              || (PADDR_slv_i >= ADDR_WIDTH'(NUM_REGS * 4))
              || (PWRITE_slv_i && (PADDR_slv_i < ADDR_WIDTH'(4)));

  apb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE)
  ) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (we_c),
    .waddr (idx_q),
    .wdata (wdata_q),
    .raddr (idx_c),
    .rdata (rd_word)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (setup_c) state_nx = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (!PSEL_slv_i)         state_nx = ST_IDLE;
        else if (cnt == CW'(1))  state_nx = ST_RESP;
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Response values are prepared on the edge entering RESP so they line up with PREADY
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    we_c      = (state == ST_RESP) && PSEL_slv_i && PENABLE_slv_i && write_q && !err_q;
    if (state_nx == ST_RESP) begin
      pready_d = 1'b1;
      if (state == ST_IDLE) begin
        pslverr_d = err_c;
        prdata_d  = err_c ? '0 : rd_word;
      end else begin
        pslverr_d = err_q;
        prdata_d  = rdata_q;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt           <= '0;
      idx_q         <= '0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      PRDATA_slv_o  <= '0;
      PREADY_slv_o  <= 1'b0;
      PSLVERR_slv_o <= 1'b0;
    end else begin
      PRDATA_slv_o  <= prdata_d;
      PREADY_slv_o  <= pready_d;
      PSLVERR_slv_o <= pslverr_d;
      if ((state == ST_IDLE) && setup_c) begin
        cnt     <= CW'(WAIT_CYCLES);
        idx_q   <= idx_c;
        write_q <= PWRITE_slv_i;
        err_q   <= err_c;
        wdata_q <= PWDATA_slv_i;
        rdata_q <= err_c ? '0 : rd_word;
      end else if (state == ST_WAIT) begin
        cnt <= (state_nx == ST_WAIT) ? cnt - CW'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: a 2-wait-state instance and a 0-wait-state instance.
module tb_apb_slave_regbank;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        psel2, psel0, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata2, prdata0;
  logic        pready2, pready0, pslverr2, pslverr0;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  always #5 PCLK = ~PCLK;

  apb_slave_regbank #(.WAIT_CYCLES(2)) dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL_slv_i(psel2), .PENABLE_slv_i(penable),
    .PWRITE_slv_i(pwrite), .PADDR_slv_i(paddr), .PWDATA_slv_i(pwdata),
    .PRDATA_slv_o(prdata2), .PREADY_slv_o(pready2), .PSLVERR_slv_o(pslverr2)
  );

  apb_slave_regbank #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL_slv_i(psel0), .PENABLE_slv_i(penable),
    .PWRITE_slv_i(pwrite), .PADDR_slv_i(paddr), .PWDATA_slv_i(pwdata),
    .PRDATA_slv_o(prdata0), .PREADY_slv_o(pready0), .PSLVERR_slv_o(pslverr0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Setup then access phase; returns on the PREADY cycle with PSEL/PENABLE still high
  task automatic xfer(input bit sel0, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdat, output logic err, output int rcyc);
    @(posedge PCLK); #1;
    psel2 = !sel0; psel0 = sel0; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge PCLK); #1;
    penable = 1'b1; rcyc = 0; rdat = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (sel0 ? pready0 : pready2) begin
        rcyc = i;
        rdat = sel0 ? prdata0 : prdata2;
        err  = sel0 ? pslverr0 : pslverr2;
        break;
      end
      @(posedge PCLK); #1;
    end
  endtask

  task automatic go_idle();
    @(posedge PCLK); #1;
    psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    PRESETn = 1'b0; psel2 = 1'b1; psel0 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = 32'h4; pwdata = '0;

    repeat (3) begin
      @(posedge PCLK); #1;
      chk("rst_pready", 32'(pready2), 32'd0);
      chk("rst_pslverr", 32'(pslverr2), 32'd0);
      chk("rst_prdata", prdata2, 32'd0);
    end
    PRESETn = 1'b1; psel2 = 1'b0;

    xfer(1'b0, 1'b0, 32'h4, 32'h0, rd, er, cyc);
    chk("rd4_after_rst", rd, 32'h0);
    chk("rd4_cyc", 32'(cyc), 32'd3);

    xfer(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, rd, er, cyc);
    chk("wr8_cyc", 32'(cyc), 32'd3);
    chk("wr8_err", 32'(er), 32'd0);
    xfer(1'b0, 1'b0, 32'h8, 32'h0, rd, er, cyc);
    chk("rd8_cyc", 32'(cyc), 32'd3);
    chk("rd8_err", 32'(er), 32'd0);
    chk("rd8_data", rd, 32'hDEADBEEF);

    xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, er, cyc);
    chk("id_data", rd, 32'hA9B0_0001);
    chk("id_err", 32'(er), 32'd0);
    xfer(1'b0, 1'b1, 32'h0, 32'h1234, rd, er, cyc);
    chk("id_wr_err", 32'(er), 32'd1);
    chk("id_wr_cyc", 32'(cyc), 32'd3);
    xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, er, cyc);
    chk("id_reread", rd, 32'hA9B0_0001);

    xfer(1'b0, 1'b1, 32'h4, 32'h1111_1111, rd, er, cyc);
    chk("wr4_err", 32'(er), 32'd0);
    xfer(1'b0, 1'b0, 32'h20, 32'h0, rd, er, cyc);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_data", rd, 32'h0);
    xfer(1'b0, 1'b1, 32'h6, 32'hFFFF_FFFF, rd, er, cyc);
    chk("misal_err", 32'(er), 32'd1);
    xfer(1'b0, 1'b0, 32'h4, 32'h0, rd, er, cyc);
    chk("reg1_kept", rd, 32'h1111_1111);
    xfer(1'b0, 1'b0, 32'h8, 32'h0, rd, er, cyc);
    chk("reg2_kept", rd, 32'hDEADBEEF);
    go_idle();

    xfer(1'b1, 1'b1, 32'h4, 32'h55, rd, er, cyc);
    chk("w0_cyc", 32'(cyc), 32'd1);
    chk("w0_err", 32'(er), 32'd0);
    xfer(1'b1, 1'b0, 32'h4, 32'h0, rd, er, cyc);
    chk("w0_b2b_cyc", 32'(cyc), 32'd1);
    chk("w0_b2b_data", rd, 32'h55);
    go_idle();

    // Master abort during wait states
    @(posedge PCLK); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hAA;
    @(posedge PCLK); #1;
    penable = 1'b1;
    chk("abort_c1_pready", 32'(pready2), 32'd0);
    @(posedge PCLK); #1;
    chk("abort_c2_pready", 32'(pready2), 32'd0);
    psel2 = 1'b0; penable = 1'b0;
    repeat (3) begin
      @(posedge PCLK); #1;
      chk("abort_no_pready", 32'(pready2), 32'd0);
    end
    xfer(1'b0, 1'b0, 32'hC, 32'h0, rd, er, cyc);
    chk("abort_rdC", rd, 32'h0);
    chk("abort_rdC_cyc", 32'(cyc), 32'd3);
    go_idle();

    // Reset in the last wait cycle, where PREADY would otherwise follow
    @(posedge PCLK); #1;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    chk("mrst_pready", 32'(pready2), 32'd0);
    chk("mrst_pslverr", 32'(pslverr2), 32'd0);
    chk("mrst_prdata", prdata2, 32'd0);
    PRESETn = 1'b1; psel2 = 1'b0; penable = 1'b0;

    xfer(1'b0, 1'b0, 32'h8, 32'h0, rd, er, cyc);
    chk("mrst_rd8_cleared", rd, 32'h0);
    chk("mrst_rd8_cyc", 32'(cyc), 32'd3);
    xfer(1'b0, 1'b1, 32'h10, 32'h77, rd, er, cyc);
    chk("mrst_wr_err", 32'(er), 32'd0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, er, cyc);
    chk("mrst_rd_data", rd, 32'h77);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
